// File: rtl/cardinal_nic_dma.sv
// -----------------------------------------------------------------------------
// cardinal_nic_dma
//   DMA initiator on the processor side of a cardinal_nic. A start pulse
//   launches one run that streams tx_count packets from dmem into the NIC
//   output channel and drains rx_count packets from the NIC input channel
//   into dmem. The two directions are serviced by strict alternation, one
//   status poll each per lap, so neither direction can starve the other.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   start                 one-cycle run request, honoured only when idle
//   tx_base / tx_count    transmit block start address and packet count
//   rx_base / rx_count    receive block start address and packet count
//   busy / done / err     run in progress, completion pulse, watchdog abort
//   tx_sent / rx_got      packets moved in the current / last run
//   mem*                  dmem master port (memDin is combinational)
//   nic*                  NIC register port (nicDin is combinational,
//                         status flag is nicDin[DATA_W-1], [0:N-1] order)
//
// Build option
//   CARDINAL_DMA_TIMEOUT_EN  adds a stall watchdog of TIMEOUT_CYCLES cycles;
//                            when undefined, err is tied low and a run waits
//                            indefinitely on a stuck ring.
// -----------------------------------------------------------------------------
module cardinal_nic_dma #(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 8,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] tx_base,
  input  logic [CNT_W-1:0]  tx_count,
  input  logic [ADDR_W-1:0] rx_base,
  input  logic [CNT_W-1:0]  rx_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  tx_sent,
  output logic [CNT_W-1:0]  rx_got,
  output logic              memEn,
  output logic              memWrEn,
  output logic [ADDR_W-1:0] memAddr,
  output logic [0:DATA_W-1] memDout,
  input  logic [0:DATA_W-1] memDin,
  output logic              nicEn,
  output logic              nicWrEn,
  output logic [1:0]        nicAddr,
  output logic [0:DATA_W-1] nicDout,
  input  logic [0:DATA_W-1] nicDin
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_POLL_OUT = 3'd1,
    S_SEND     = 3'd2,
    S_POLL_IN  = 3'd3,
    S_RECV     = 3'd4,
    S_FIN      = 3'd5
  } state_t;

  localparam logic [1:0] NIC_IN_BUF  = 2'b00;
  localparam logic [1:0] NIC_IN_STS  = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF = 2'b10;
  localparam logic [1:0] NIC_OUT_STS = 2'b11;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] tx_ptr_q, tx_ptr_d;
  logic [ADDR_W-1:0] rx_ptr_q, rx_ptr_d;
  logic [CNT_W-1:0]  tx_rem_q, tx_rem_d;
  logic [CNT_W-1:0]  rx_rem_q, rx_rem_d;
  logic [CNT_W-1:0]  tx_sent_q, tx_sent_d;
  logic [CNT_W-1:0]  rx_got_q, rx_got_d;

  // Status flag read back during either poll state.
  logic nic_status;
  assign nic_status = nicDin[DATA_W-1];

`ifdef CARDINAL_DMA_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    tx_ptr_d  = tx_ptr_q;
    rx_ptr_d  = rx_ptr_q;
    tx_rem_d  = tx_rem_q;
    rx_rem_d  = rx_rem_q;
    tx_sent_d = tx_sent_q;
    rx_got_d  = rx_got_q;
`ifdef CARDINAL_DMA_TIMEOUT_EN
    stall_d   = stall_q;
    err_d     = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          tx_ptr_d  = tx_base;
          rx_ptr_d  = rx_base;
          tx_rem_d  = tx_count;
          rx_rem_d  = rx_count;
          tx_sent_d = '0;
          rx_got_d  = '0;
`ifdef CARDINAL_DMA_TIMEOUT_EN
          stall_d   = '0;
          err_d     = 1'b0;
`endif
          if (tx_count == '0 && rx_count == '0) state_d = S_FIN;
          else                                  state_d = S_POLL_OUT;
        end
      end
      S_POLL_OUT: begin
        // Out-status low means the NIC output buffer can take a packet.
        if (tx_rem_q != '0 && !nic_status) state_d = S_SEND;
        else                               state_d = S_POLL_IN;
      end
      S_SEND: begin
        tx_ptr_d  = tx_ptr_q + ADDR_W'(1);
        tx_rem_d  = tx_rem_q - CNT_W'(1);
        tx_sent_d = tx_sent_q + CNT_W'(1);
        state_d   = S_POLL_IN;
      end
      S_POLL_IN: begin
        if (rx_rem_q == '0) state_d = (tx_rem_q == '0) ? S_FIN : S_POLL_OUT;
        else if (nic_status) state_d = S_RECV;
        else                 state_d = S_POLL_OUT;
      end
      S_RECV: begin
        rx_ptr_d = rx_ptr_q + ADDR_W'(1);
        rx_rem_d = rx_rem_q - CNT_W'(1);
        rx_got_d = rx_got_q + CNT_W'(1);
        state_d  = S_POLL_OUT;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef CARDINAL_DMA_TIMEOUT_EN
    // Any data movement counts as progress; polling without movement is a
    // stall. Expiry overrides the normal poll transition.
    if (state_q == S_SEND || state_q == S_RECV) begin
      stall_d = '0;
    end else if (state_q == S_POLL_OUT || state_q == S_POLL_IN) begin
      if (stall_q >= STALL_W'(TIMEOUT_CYCLES - 1)) begin
        stall_d = '0;
        err_d   = 1'b1;
        state_d = S_FIN;
      end else begin
        stall_d = stall_q + STALL_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tx_ptr_q  <= '0;
      rx_ptr_q  <= '0;
      tx_rem_q  <= '0;
      rx_rem_q  <= '0;
      tx_sent_q <= '0;
      rx_got_q  <= '0;
`ifdef CARDINAL_DMA_TIMEOUT_EN
      stall_q   <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tx_ptr_q  <= tx_ptr_d;
      rx_ptr_q  <= rx_ptr_d;
      tx_rem_q  <= tx_rem_d;
      rx_rem_q  <= rx_rem_d;
      tx_sent_q <= tx_sent_d;
      rx_got_q  <= rx_got_d;
`ifdef CARDINAL_DMA_TIMEOUT_EN
      stall_q   <= stall_d;
      err_q     <= err_d;
`endif
    end
  end

  // Bus outputs decode the registered state only, so reset forces them all
  // low immediately through S_IDLE.
  always_comb begin
    memEn   = 1'b0;
    memWrEn = 1'b0;
    memAddr = '0;
    memDout = '0;
    nicEn   = 1'b0;
    nicWrEn = 1'b0;
    nicAddr = 2'b00;
    nicDout = '0;
    case (state_q)
      S_POLL_OUT: begin
        if (tx_rem_q != '0) begin
          nicEn   = 1'b1;
          nicAddr = NIC_OUT_STS;
        end
      end
      S_SEND: begin
        memEn   = 1'b1;
        memAddr = tx_ptr_q;
        nicEn   = 1'b1;
        nicWrEn = 1'b1;
        nicAddr = NIC_OUT_BUF;
        nicDout = memDin;
      end
      S_POLL_IN: begin
        if (rx_rem_q != '0) begin
          nicEn   = 1'b1;
          nicAddr = NIC_IN_STS;
        end
      end
      S_RECV: begin
        nicEn   = 1'b1;
        nicAddr = NIC_IN_BUF;
        memEn   = 1'b1;
        memWrEn = 1'b1;
        memAddr = rx_ptr_q;
        memDout = nicDin;
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_FIN);
  assign tx_sent = tx_sent_q;
  assign rx_got  = rx_got_q;

`ifdef CARDINAL_DMA_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/cardinal_nic_dma.md
Name: cardinal_nic_dma

Overview:
- Hardware initiator on the processor side of a cardinal_nic. It replaces CPU polling code for bulk traffic.
- On a start pulse it streams tx_count 64-bit packets from the local dmem into the NIC output channel.
- In the same run it drains rx_count packets from the NIC input channel into dmem.
- Sits beside a node's CPU. An external mux (outside this block) hands it the dmem and NIC ports while busy=1.

Parameters:
- DATA_W, 64, packet/memory word width.
- ADDR_W, 8, dmem address width.
- CNT_W, 8, width of packet counters.
- TIMEOUT_CYCLES, 1024, watchdog limit. Used only with CARDINAL_DMA_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- tx_base  in  ADDR_W  first dmem address of the transmit block.
- tx_count  in  CNT_W  number of packets to send (0 allowed).
- rx_base  in  ADDR_W  first dmem address of the receive block.
- rx_count  in  CNT_W  number of packets to receive (0 allowed).
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at run completion.
- err  out  1  watchdog abort flag (feature only, else tied 0).
- tx_sent  out  CNT_W  packets written to the NIC this run.
- rx_got  out  CNT_W  packets read from the NIC this run.
- memEn  out  1  dmem enable.
- memWrEn  out  1  dmem write enable.
- memAddr  out  ADDR_W  dmem address.
- memDout  out  DATA_W  data to dmem.
- memDin  in  DATA_W  dmem read data, combinational from memAddr.
- nicEn  out  1  NIC enable.
- nicWrEn  out  1  NIC write enable.
- nicAddr  out  2  NIC register: 00 in-buffer, 01 in-status, 10 out-buffer, 11 out-status.
- nicDout  out  DATA_W  data to NIC.
- nicDin  in  DATA_W  NIC read data, combinational. The status bit is nicDin[63]; ports use [0:N-1] bit order.

Behaviour:
- Reset (async): FSM=IDLE. busy, done, err, memEn, memWrEn, nicEn, nicWrEn = 0. memAddr, memDout, nicAddr, nicDout, tx_sent, rx_got = 0.
- All enables are registered-state decoded. Outputs are combinational from state and pointers; no glitch requirement beyond that.
- States: IDLE, POLL_OUT, SEND, POLL_IN, RECV, FIN.
- IDLE:
  - On start, latch tx_base, tx_count, rx_base, rx_count into tx_ptr, tx_rem, rx_ptr, rx_rem.
  - Clear tx_sent and rx_got, set busy, go to POLL_OUT.
  - If both counts are 0, go directly to FIN.
- POLL_OUT:
  - If tx_rem==0, go to POLL_IN with no bus activity.
  - Otherwise nicEn=1, nicWrEn=0, nicAddr=11.
  - If nicDin[63]==0 (out buffer empty), go to SEND; else go to POLL_IN.
- SEND (one cycle):
  - memEn=1, memWrEn=0, memAddr=tx_ptr.
  - nicEn=1, nicWrEn=1, nicAddr=10, nicDout=memDin.
  - At posedge: tx_ptr+1, tx_rem-1, tx_sent+1. Go to POLL_IN.
- POLL_IN:
  - If rx_rem==0, go to POLL_OUT, or to FIN if tx_rem==0.
  - Otherwise read nicAddr=01. If nicDin[63]==1 (packet present), go to RECV; else go to POLL_OUT.
- RECV (one cycle):
  - nicEn=1, nicWrEn=0, nicAddr=00.
  - memEn=1, memWrEn=1, memAddr=rx_ptr, memDout=nicDin.
  - The NIC clears its in-status on this read. rx_ptr+1, rx_rem-1, rx_got+1. Go to POLL_OUT.
- FIN: done=1 for one cycle, busy=0 next cycle, return to IDLE. tx_sent and rx_got hold until the next start.
- Arbitration: strict TX/RX alternation. Each direction gets one poll per lap, so neither starves. Worst-case lap is 4 cycles.
- Pointers wrap modulo 2^ADDR_W (0xFF+1 -> 0x00). Counters never underflow: tx_rem and rx_rem are checked before decrementing.
- start while busy is ignored; there is no queueing.
- Reset mid-run aborts immediately. Partial dmem writes already committed remain; no NIC write is left half-done since each write is a single cycle.
- Exactly one of memEn/nicEn-only, both, or none is active per cycle as listed. memWrEn and nicWrEn are never both 1.

Optional Feature:
- Macro CARDINAL_DMA_TIMEOUT_EN.
- With the macro: a stall counter is cleared on every SEND, RECV, or start, and increments every busy cycle otherwise. On reaching TIMEOUT_CYCLES, assert err=1 (sticky until next start) and go to FIN, so done still pulses.
- Without the macro: no counter, err tied 0, and a run waits indefinitely on a stuck ring.

Test Plan:
- tx_base=0x10, tx_count=3, rx_count=0, NIC out always empty -> NIC receives dmem[0x10..0x12] in order. done pulses once. tx_sent=3, busy low after.
- rx_base=0x40, rx_count=2, NIC presents 0xAAAA...AA then 0x5555...55 -> dmem[0x40]=0xAA..AA, dmem[0x41]=0x55..55, rx_got=2, done pulses.
- tx_count=2, rx_count=2 with NIC out-status held full for 10 cycles -> RX completes first. SEND only after status clears. No memWrEn and nicWrEn overlap.
- tx_base=0xFE, tx_count=3 -> reads 0xFE, 0xFF, 0x00.
- tx_count=rx_count=0, start -> done one cycle after start with no nicEn or memEn activity. Then a second start while busy is ignored.
- Reset asserted mid-SEND: all outputs 0 asynchronously. With CARDINAL_DMA_TIMEOUT_EN, TIMEOUT_CYCLES=16, and in-status never set with rx_count=1 -> err=1 and done pulse about 16 cycles after the last progress.
